seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Time-multiplexed multi-digit 7-segment driver for the 8x8 multiplier result.
- Up to 16-bit product, shown as 4 hex digits by default.
- Generalises the 3-bit single-digit decoder to full 0-F hex, N digits, refresh scanning, tear-free value update, leading-zero blanking and selectable output polarity.
- Sits between the multiplier output register and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8); value width is 4*NUM_DIGITS
REFRESH_DIV, 16, clk cycles each digit stays lit (>=2)
ACTIVE_LOW, 0, 1 = seg and an are driven inverted (common-anode boards)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
value  input  4*NUM_DIGITS  binary value to display; nibble i -> digit i, digit 0 = least significant
load  input  1  capture value into pending register this cycle
en  input  1  display enable; low = all digits dark, scan frozen
blank_lz  input  1  suppress leading zero digits
seg  output [0:6]  segment pattern, bit 0 = a ... bit 6 = g
an  output  NUM_DIGITS  one-hot digit enable, an[i] lights digit i
frame_done  output  1  one-cycle pulse at the end of each full scan frame

Behaviour:
- Reset (async assert, sync release): prescaler = 0, digit index = 0, pending = 0, display = 0, frame_done = 0.
- During reset, seg and an are driven to the off level: all 0, or all 1 when ACTIVE_LOW.
- Prescaler counts 0..REFRESH_DIV-1 while en = 1. tick = en & (prescaler == REFRESH_DIV-1). Prescaler wraps to 0 on tick.
- On tick, the digit index advances, wrapping NUM_DIGITS-1 -> 0.
- frame_done = registered (tick & index == NUM_DIGITS-1).
- load = 1 writes value into the pending register.
- pending is copied to the display register only at a frame boundary, i.e. on the tick that wraps the index to 0. This gives tear-free update.
- If load and the wrapping tick occur in the same cycle, the new value goes straight to display for the frame that starts.
- Multiple loads within one frame: the last one wins.
- Hex decode (a..g), indexed by nibble:
  0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011, 5 1011011, 6 1011111, 7 1110000,
  8 1111111, 9 1111011, A 1110111, b 0011111, C 1001110, d 0111101, E 1001111, F 1000111.
- seg and an are registered.
- Latency: one clk from an index change or display update to the output change.
- After reset release with en = 1, an = one-hot(0) and seg = pattern of display digit 0 from the first clock edge.
- Leading-zero blank: digit i (i > 0) is blank when blank_lz = 1 and display nibbles i..NUM_DIGITS-1 are all 0.
  - A blank digit drives seg and an to the off level.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- en = 0: prescaler and index hold, seg and an go off on the next clock, frame_done = 0.
  - load is still accepted into pending.
  - When en returns to 1, the scan resumes from the held index and prescaler.
- ACTIVE_LOW = 1: seg and an are the bitwise inverse of the active-high values, including the reset and off states.
- Reset asserted mid-frame: immediate return to reset state. Pending and display are cleared, so no stale value survives.
- NUM_DIGITS = 1: the index is constant 0, every tick is a frame end, an = 1 permanently while en = 1.

Decomposition:
- Package seg7_pkg:
  - 16-entry segment code constant table (above).
  - SEG_OFF constant.
  - function hex_to_seg(4-bit) -> [0:6].
  - Helper function giving the index width from NUM_DIGITS (minimum 1).
- Sub-module seg7_hex_decode: combinational 4-bit -> [0:6] decoder built on the package table. Instantiated once, fed by the nibble mux.
- Scan, prescaler, pending/display registers and blanking stay in seg7_scan_driver.

Test Plan:
- Scan order: NUM_DIGITS=4, REFRESH_DIV=4; load 16'h12AF after reset, en=1.
  - an sequence 0001,0010,0100,1000, each held 4 cycles.
  - seg F=1000111, A=1110111, 2=1101101, 1=0110000.
  - The first frame shows 0 until the wrap.
  - frame_done pulses once per 16 cycles.
- Leading-zero blank: value 16'h0005, blank_lz=1.
  - Digit 0 shows 1011011.
  - Digits 1-3 have an and seg off.
  - With value 16'h0000, only digit 0 is lit, showing 1111110.
- Tear-free load: display 16'h1111; load 16'h2222 while index = 2.
  - Digits 2 and 3 still show 1 for the current frame.
  - All digits show 2 from the next frame.
  - Load coincident with the wrapping tick takes effect in that frame.
- Enable: drop en for 10 cycles mid-digit.
  - seg/an go off one cycle later; index and prescaler are frozen; frame_done stays 0.
  - On re-enable, the remaining dwell completes before the next digit.
- ACTIVE_LOW=1, value 16'h0008: digit 0 seg = 0000000, an = 1110; reset state gives seg = 1111111 and an = 1111.
- Reset mid-frame at index 3 with value 16'hFFFF.
  - seg/an go off asynchronously.
  - After release, digit 0 shows 0 (1111110) and frame_done stays 0 until the next full frame.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
// Segment vectors are declared [0:6], where bit 0 is segment a and bit 6 is segment g.
package seg7_pkg;

  // Active-high level of a dark segment.
  localparam logic [0:6] SEG_OFF = 7'b0000000;

  // Hex glyph table, indexed by nibble value. Each entry is written in a..g order.
  localparam logic [0:6] SEG_TABLE [0:15] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

  // Active-high segment pattern for one hex nibble.
  function automatic logic [0:6] hex_to_seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

  // Width of the digit index register.
  // A single-digit display still gets a 1-bit index.
  function automatic int idx_width(input int num_digits);
    return (num_digits <= 1) ? 1 : $clog2(num_digits);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to a..g segment decoder (active-high).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [0:6] seg_o
);

  // Table lookup; output polarity is handled by the scan driver.
  always_comb begin
    seg_o = hex_to_seg(nibble_i);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex display driver.
// A prescaler sets how long each digit stays lit.
// A new value is staged in a pending register and becomes visible only at a frame wrap,
// so a frame never mixes old and new digits.
// Leading-zero blanking and output polarity are applied before the output registers.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 16,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    en,
  input  logic                    blank_lz,
  output logic [0:6]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int                    IDX_W    = idx_width(NUM_DIGITS);
  localparam int                    PRE_W    = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  // XOR masks that turn active-high levels into pin levels.
  localparam logic [0:6]            SEG_POL  = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_POL   = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [0:6]            SEG_DARK = SEG_OFF ^ SEG_POL;
  localparam logic [NUM_DIGITS-1:0] AN_DARK  = AN_POL;

  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] display_q, display_d;
  logic [0:6]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tick;
  logic                    wrap;
  logic [NUM_DIGITS-1:0]   digit_blank;
  logic [3:0]              cur_nibble;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   cur_an;
  logic [0:6]              cur_seg;

  // A digit above 0 is blank when it and every more-significant nibble are zero.
  // Digit 0 is always lit, so a zero value still shows a single 0.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
    if (gi == 0) begin : g_d0
      assign digit_blank[gi] = 1'b0;
    end else begin : g_dn
      assign digit_blank[gi] = blank_lz && !(|display_q[4*NUM_DIGITS-1:4*gi]);
    end
  end

  // Select the nibble, blank flag and anode bit for the digit being scanned.
  always_comb begin
    cur_nibble = 4'h0;
    cur_blank  = 1'b0;
    cur_an     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nibble = display_q[4*i +: 4];
        cur_blank  = digit_blank[i];
        cur_an[i]  = 1'b1;
      end
    end
  end

  seg7_hex_decode u_dec (
    .nibble_i (cur_nibble),
    .seg_o    (cur_seg)
  );

  assign tick = en && (pre_q == PRE_LAST);
  assign wrap = tick && (idx_q == IDX_LAST);

  // Next-state logic for the scan counters, the staged value and the output levels.
  always_comb begin
    pre_d        = pre_q;
    idx_d        = idx_q;
    pending_d    = load ? value : pending_q;
    display_d    = display_q;
    frame_done_d = wrap;
    seg_d        = SEG_DARK;
    an_d         = AN_DARK;

    if (en) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
    // pending_d already includes a load in this same cycle.
    // A load that coincides with the wrap therefore appears in the frame that starts now.
    if (wrap) begin
      display_d = pending_d;
    end
    if (en && !cur_blank) begin
      seg_d = cur_seg ^ SEG_POL;
      an_d  = cur_an ^ AN_POL;
    end
  end

  // State and output registers; reset clears everything and drives the outputs dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q        <= '0;
      idx_q        <= '0;
      pending_q    <= '0;
      display_q    <= '0;
      seg_q        <= SEG_DARK;
      an_q         <= AN_DARK;
      frame_done_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      display_q    <= display_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
